// File: rtl/hht_pkg.sv
// Shared types and constants for the HHT sparse-matrix x dense-vector engine.
package hht_pkg;

    localparam int unsigned N_ROWS_DEF = 16;
    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned RAW        = 5;

    localparam logic [RAW-1:0] REG_COL = 5'd6;
    localparam logic [RAW-1:0] REG_VEC = 5'd8;
    localparam logic [RAW-1:0] REG_MAT = 5'd9;
    localparam logic [RAW-1:0] REG_ROW = 5'd15;

    typedef enum logic [2:0] {
        BASE0,
        BASE1,
        RPTR,
        FETCH,
        MAC,
        RDONE,
        DONE
    } hht_state_e;

endpackage

// File: rtl/hht_mac.sv
// Truncating 32x32 multiply-accumulate with synchronous clear and enable.
// sum_c is the next accumulator value, exposed so the caller can store it per row.
module hht_mac
    import hht_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum_c
);

    logic [DW-1:0] acc_q;

    assign sum_c = acc_q + a * b;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum_c;
        end
    end

endmodule

// File: rtl/hht_spmv_control.sv
// HHT engine computing y = A*x for a CSR matrix, one dot product per row into acc[].
// Optional HHT_WATCH_EN: capture the column index fetched at matrix-value address cpu_addr.
module hht_spmv_control
    import hht_pkg::*;
#(
    parameter int unsigned N_ROWS = N_ROWS_DEF,
    parameter int unsigned DW     = DW_DEF
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [DW-1:0]  base_dat_a,
    input  logic [DW-1:0]  base_dat_b,
    output logic [DW-1:0]  addr1,
    output logic [DW-1:0]  addr2,
    input  logic [DW-1:0]  dataIn1,
    input  logic [DW-1:0]  dataIn2,
    input  logic           RD,
    input  logic [DW-1:0]  csize,
    input  logic [DW-1:0]  cpu_addr,
    output logic           hht,
    output logic [RAW-1:0] regaddr1,
    output logic [RAW-1:0] regaddr2,
    output logic [RAW-1:0] rdata,
    output logic [RAW-1:0] adata
);

    localparam int unsigned RW = $clog2(N_ROWS + 1);
    localparam int unsigned IW = $clog2(N_ROWS);

    hht_state_e    state;
    logic [RW-1:0] r;
    logic [IW-1:0] ridx;
    logic [DW-1:0] col_base, row_base, vec_base, mat_base;
    logic [DW-1:0] k, row_end, val;
    logic [DW-1:0] lim_c, ptr_c, start_c, k_nxt_c, mac_sum_c;
    logic [DW-1:0] acc [N_ROWS];

    // Index region starts after the row-pointer copy; row ends are clamped to its size.
    assign lim_c   = csize - DW'(N_ROWS + 1);
    assign ptr_c   = (dataIn1 > lim_c) ? lim_c : dataIn1;
    assign start_c = (r == '0) ? '0 : row_end;
    assign k_nxt_c = k + DW'(1);
    assign ridx    = r[IW-1:0];

`ifndef HHT_WATCH_EN
    logic unused_cpu_addr;
    assign unused_cpu_addr = ^cpu_addr;
`endif

    hht_mac #(.DW(DW)) u_mac (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr   (RD && (state == RPTR)),
        .en    (RD && (state == MAC)),
        .a     (val),
        .b     (dataIn2),
        .sum_c (mac_sum_c)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= BASE0;
            addr1    <= '0;
            addr2    <= '0;
            hht      <= 1'b0;
            regaddr1 <= '0;
            regaddr2 <= '0;
            rdata    <= '0;
            adata    <= '0;
            col_base <= '0;
            row_base <= '0;
            vec_base <= '0;
            mat_base <= '0;
            r        <= '0;
            k        <= '0;
            row_end  <= '0;
            val      <= '0;
            for (int i = 0; i < int'(N_ROWS); i++) begin
                acc[i] <= '0;
            end
        end else if (RD) begin
            case (state)
                // Register indices are registered, so data is valid the cycle after they are issued.
                BASE0: begin
                    regaddr1 <= REG_COL;
                    regaddr2 <= REG_ROW;
                    if (regaddr1 == REG_COL) begin
                        col_base <= base_dat_a;
                        row_base <= base_dat_b;
                        regaddr1 <= REG_VEC;
                        regaddr2 <= REG_MAT;
                        state    <= BASE1;
                    end
                end
                BASE1: begin
                    vec_base <= base_dat_a;
                    mat_base <= base_dat_b;
                    addr1    <= row_base + DW'(1);
                    state    <= RPTR;
                end
                RPTR: begin
                    row_end <= ptr_c;
                    k       <= start_c;
                    if (start_c < ptr_c) begin
                        addr1 <= col_base + DW'(N_ROWS + 1) + start_c;
                        addr2 <= mat_base + start_c;
                        state <= FETCH;
                    end else begin
                        state <= RDONE;
                    end
                end
                FETCH: begin
                    val   <= dataIn2;
                    addr2 <= vec_base + dataIn1;
`ifdef HHT_WATCH_EN
                    if (addr2 == cpu_addr) begin
                        adata <= dataIn1[RAW-1:0];
                    end
`endif
                    state <= MAC;
                end
                MAC: begin
                    acc[ridx] <= mac_sum_c;
                    k         <= k_nxt_c;
                    if (k_nxt_c < row_end) begin
                        addr1 <= col_base + DW'(N_ROWS + 1) + k_nxt_c;
                        addr2 <= mat_base + k_nxt_c;
                        state <= FETCH;
                    end else begin
                        state <= RDONE;
                    end
                end
                RDONE: begin
                    rdata <= RAW'(r);
                    r     <= r + RW'(1);
                    if ((r + RW'(1)) < RW'(N_ROWS)) begin
                        addr1 <= row_base + DW'(r) + DW'(2);
                        state <= RPTR;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hht <= 1'b1;
                end
                default: begin
                    state <= BASE0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hht_spmv_control.sv
// Directed bench for hht_spmv_control: table-driven start-up/stall trace, full run, reset rerun.
module tb_hht_spmv_control;

    localparam int N = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] base_dat_a, base_dat_b;
    logic [31:0] addr1, addr2, dataIn1, dataIn2;
    logic        RD = 1'b0;
    logic [31:0] csize = 32'd179;
    logic [31:0] cpu_addr = 32'd126;
    logic        hht;
    logic [4:0]  regaddr1, regaddr2, rdata, adata;

    logic [31:0] mem [0:32767];
    logic [31:0] rf [0:31];

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        rd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] acc0;
    } vec_t;

    vec_t        tv [13];
    int          rp [17];
    logic [31:0] colv [165];
    logic [31:0] valv [165];
    logic [31:0] xv [13];
    logic [31:0] exp_acc [N];
    logic [4:0]  exp_adata;

    always #5 Clk = ~Clk;

    assign dataIn1    = mem[addr1[14:0]];
    assign dataIn2    = mem[addr2[14:0]];
    assign base_dat_a = rf[regaddr1];
    assign base_dat_b = rf[regaddr2];

    hht_spmv_control dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .base_dat_a (base_dat_a),
        .base_dat_b (base_dat_b),
        .addr1      (addr1),
        .addr2      (addr2),
        .dataIn1    (dataIn1),
        .dataIn2    (dataIn2),
        .RD         (RD),
        .csize      (csize),
        .cpu_addr   (cpu_addr),
        .hht        (hht),
        .regaddr1   (regaddr1),
        .regaddr2   (regaddr2),
        .rdata      (rdata),
        .adata      (adata)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_to_done(input int start, output int cyc);
        cyc = start;
        RD  = 1'b1;
        while (!hht && cyc < 1000) begin
            step();
            cyc++;
        end
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_acc%0d", tag, i), dut.acc[i], exp_acc[i]);
        end
        check({tag, "_hht"}, 32'(hht), 32'd1);
        check({tag, "_rdata"}, 32'(rdata), 32'd15);
        check({tag, "_addr1_held"}, addr1, 32'd28706);
        check({tag, "_addr2_held"}, addr2, 32'd7);
        check({tag, "_adata"}, 32'(adata), 32'(exp_adata));
    endtask

    initial begin
        int          cyc;
        int          lim;
        int          prev_e;
        int          e;
        logic [31:0] sum;

        rp = '{0, 4, 10, 10, 21, 30, 45, 45, 60, 75, 90, 100, 120, 140, 150, 164, 165};
        for (int k = 0; k < 165; k++) begin
            colv[k] = 32'(k % 13);
            valv[k] = 32'(k * 3 + 5);
        end
        valv[0] = 32'd76;
        valv[1] = 32'd41;
        valv[5] = 32'hFFFF_FFF0;
        for (int c = 0; c < 13; c++) xv[c] = 32'(c * 11 + 3);
        xv[0] = 32'd47;
        xv[1] = 32'd86;

        for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_0000 + 32'(i);
        rf[6]  = 32'd2690;
        rf[15] = 32'd28690;
        rf[8]  = 32'd2;
        rf[9]  = 32'd90;
        for (int i = 0; i < 17; i++) begin
            mem[28690 + i] = 32'(rp[i]);
            mem[2690 + i]  = 32'(rp[i]);
        end
        for (int k = 0; k < 165; k++) begin
            mem[2707 + k] = colv[k];
            mem[90 + k]   = valv[k];
        end
        for (int c = 0; c < 13; c++) mem[2 + c] = xv[c];

        // Software CSR reference with the column-region clamp.
        lim    = 179 - (N + 1);
        prev_e = 0;
        for (int r = 0; r < N; r++) begin
            e   = (rp[r + 1] > lim) ? lim : rp[r + 1];
            sum = 32'd0;
            for (int k = prev_e; k < e; k++) sum = sum + valv[k] * xv[colv[k]];
            exp_acc[r] = sum;
            prev_e     = e;
        end
`ifdef HHT_WATCH_EN
        exp_adata = 5'd10;
`else
        exp_adata = 5'd0;
`endif

        tv[0]  = '{1'b1, 5'd6, 5'd15, 32'd0,     32'd0,  32'd0};
        tv[1]  = '{1'b1, 5'd8, 5'd9,  32'd0,     32'd0,  32'd0};
        tv[2]  = '{1'b1, 5'd8, 5'd9,  32'd28691, 32'd0,  32'd0};
        tv[3]  = '{1'b1, 5'd8, 5'd9,  32'd2707,  32'd90, 32'd0};
        tv[4]  = '{1'b1, 5'd8, 5'd9,  32'd2707,  32'd2,  32'd0};
        tv[5]  = '{1'b1, 5'd8, 5'd9,  32'd2708,  32'd91, 32'd3572};
        tv[6]  = '{1'b1, 5'd8, 5'd9,  32'd2708,  32'd3,  32'd3572};
        for (int i = 7; i < 12; i++) tv[i] = '{1'b0, 5'd8, 5'd9, 32'd2708, 32'd3, 32'd3572};
        tv[12] = '{1'b1, 5'd8, 5'd9,  32'd2709,  32'd92, 32'd7098};

        repeat (2) @(posedge Clk);
        #1;
        check("rst_hht", 32'(hht), 32'd0);
        check("rst_addr1", addr1, 32'd0);
        check("rst_addr2", addr2, 32'd0);
        check("rst_regaddr1", 32'(regaddr1), 32'd0);
        check("rst_regaddr2", 32'(regaddr2), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_adata", 32'(adata), 32'd0);
        check("rst_acc0", dut.acc[0], 32'd0);
        Rst = 1'b1;

        cyc = 0;
        for (int i = 0; i < 13; i++) begin
            RD = tv[i].rd;
            step();
            if (tv[i].rd) cyc++;
            check($sformatf("v%0d_regaddr1", i), 32'(regaddr1), 32'(tv[i].ra1));
            check($sformatf("v%0d_regaddr2", i), 32'(regaddr2), 32'(tv[i].ra2));
            check($sformatf("v%0d_addr1", i), addr1, tv[i].a1);
            check($sformatf("v%0d_addr2", i), addr2, tv[i].a2);
            check($sformatf("v%0d_acc0", i), dut.acc[0], tv[i].acc0);
        end

        run_to_done(cyc, cyc);
        check("run1_under_400_cycles", 32'(cyc < 400), 32'd1);
        check_results("run1");
        repeat (3) step();
        check("done_hht_held", 32'(hht), 32'd1);
        check("done_addr1_held", addr1, 32'd28706);

        // Fresh run, then an asynchronous reset in the middle of row 3.
        Rst = 1'b0;
        #2;
        Rst = 1'b1;
        repeat (50) step();
        check("pre_rst_rdata", 32'(rdata), 32'd2);
        #2;
        Rst = 1'b0;
        #1;
        check("midrst_hht", 32'(hht), 32'd0);
        check("midrst_addr1", addr1, 32'd0);
        check("midrst_addr2", addr2, 32'd0);
        check("midrst_regaddr1", 32'(regaddr1), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_acc0", dut.acc[0], 32'd0);
        Rst = 1'b1;

        run_to_done(0, cyc);
        check("run2_under_400_cycles", 32'(cyc < 400), 32'd1);
        check_results("run2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
